// File: rtl/multiword_add_sequencer.sv
// Word-serial multi-precision add/subtract: one shared N-bit ripple adder is
// walked across WORDS slices, with the inter-slice carry held in a register.

module n_bit_adder #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);
  logic [n:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < n; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[n];
endmodule

// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready/out_valid come from registered state only; once out_valid
// rises, sum/cout/ovf stay stable until the edge that completes the transfer.
module multiword_add_sequencer #(
  parameter int N     = 8,
  parameter int WORDS = 4,
  localparam int W    = N * WORDS,
  localparam int IW   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_reg, b_reg;
  logic [W-1:0]   sum_r;
  logic           carry_r;
  logic [IW-1:0]  idx_q;
  logic           cout_r, ovf_r;
  logic [N-1:0]   slice_sum;
  logic           slice_cout;
  logic           last_slice;
  logic           accept;

  assign accept     = (state_q == IDLE) && in_valid;
  assign last_slice = (idx_q == IW'(WORDS - 1));

  n_bit_adder #(.n(N)) u_adder (
    .a    (a_reg[idx_q*N +: N]),
    .b    (b_reg[idx_q*N +: N]),
    .cin  (carry_r),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted at capture and the +1 enters as
  // the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      idx_q   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= sub ? ~b : b;
      carry_r <= sub;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      sum_r[idx_q*N +: N] <= slice_sum;
      carry_r             <= slice_cout;
      if (last_slice) begin
        idx_q  <= '0;
        cout_r <= slice_cout;
        ovf_r  <= (a_reg[W-1] == b_reg[W-1]) && (slice_sum[N-1] != a_reg[W-1]);
      end else begin
        idx_q  <= idx_q + IW'(1);
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: directed cases, backpressure, reset abort
// and random regression on a WORDS=4 and a WORDS=1 instance.

module tb_multiword_add_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WORDS=4 instance
  logic        in_valid = 1'b0, out_ready = 1'b0, sub = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf, busy;
  logic [31:0] sum;
  logic [1:0]  dbg_state;

  // WORDS=1 instance
  logic        in_valid1 = 1'b0, out_ready1 = 1'b0, sub1 = 1'b0;
  logic [7:0]  a1 = '0, b1 = '0;
  logic        in_ready1, out_valid1, cout1, ovf1, busy1;
  logic [7:0]  sum1;
  logic [1:0]  dbg_state1;

  int total = 0;
  int bad   = 0;

  // {cout, ovf, sum}
  logic [33:0] exp_q[$];
  logic [33:0] exp1_q[$];

  multiword_add_sequencer #(.N(8), .WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .dbg_state(dbg_state)
  );

  multiword_add_sequencer #(.N(8), .WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1), .dbg_state(dbg_state1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Width-w reference built from a W+1-bit sum of A and the two's complement of B.
  function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic s, input int w);
    logic [63:0] mask, bb, t, sm;
    logic c, o, aw, bw, sw;
    mask = (64'd1 << w) - 64'd1;
    bb   = s ? (~{32'd0, bv} & mask) : ({32'd0, bv} & mask);
    t    = ({32'd0, av} & mask) + bb + {63'd0, s};
    sm   = t & mask;
    c    = t[w];
    aw   = av[w-1];
    bw   = bv[w-1];
    sw   = sm[w-1];
    o    = s ? ((aw != bw) && (sw != aw)) : ((aw == bw) && (sw != aw));
    return {c, o, sm[31:0]};
  endfunction

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic send4(input logic [31:0] av, input logic [31:0] bv, input logic s);
    int n = 0;
    in_valid = 1'b1; a = av; b = bv; sub = s;
    while (in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("send4_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(model(av, bv, s, 32));
  endtask

  task automatic wait_ov4(output int lat);
    int n = 0;
    while (out_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("out_valid_timeout", 64'(n), 64'd0);
    lat = n;
  endtask

  task automatic compare4();
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check("sum",  64'(sum),  64'(e[31:0]));
      check("cout", 64'(cout), 64'(e[33]));
      check("ovf",  64'(ovf),  64'(e[32]));
    end
  endtask

  task automatic recv4(input int max_stall, output int lat);
    wait_ov4(lat);
    repeat ($urandom_range(0, max_stall)) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    compare4();
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic dir4(input string tag, input logic [31:0] av, input logic [31:0] bv,
                      input logic s, input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    send4(av, bv, s);
    recv4(2, lat);
    check({tag, "_sum"},  64'(sum),  64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    check({tag, "_ovf"},  64'(ovf),  64'(eo));
  endtask

  task automatic txn1(input logic [7:0] av, input logic [7:0] bv, input logic s,
                      input int max_stall, output int lat);
    int n = 0;
    logic [33:0] e;
    in_valid1 = 1'b1; a1 = av; b1 = bv; sub1 = s;
    while (in_ready1 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("send1_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    exp1_q.push_back(model({24'd0, av}, {24'd0, bv}, s, 8));
    n = 0;
    while (out_valid1 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("out_valid1_timeout", 64'(n), 64'd0);
    lat = n;
    repeat ($urandom_range(0, max_stall)) begin @(posedge clk); #1; end
    out_ready1 = 1'b1;
    e = exp1_q.pop_front();
    check("sum1",  64'(sum1),  64'(e[7:0]));
    check("cout1", 64'(cout1), 64'(e[33]));
    check("ovf1",  64'(ovf1),  64'(e[32]));
    @(posedge clk); #1;
    out_ready1 = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] held_sum;
    logic held_c, held_o;
    logic [33:0] e;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_sum",       64'(sum),       64'd0);
    check("rst_cout",      64'(cout),      64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_state",     64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // carry ripples across a slice boundary; latency of WORDS cycles
    send4(32'h0000_00FF, 32'h0000_0001, 1'b0);
    check("run_busy", 64'(busy), 64'd1);
    recv4(0, lat);
    check("latency4", 64'(lat), 64'd4);
    check("d1_sum",  64'(sum),  64'h0000_0100);
    check("d1_cout", 64'(cout), 64'd0);
    check("d1_ovf",  64'(ovf),  64'd0);

    dir4("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    dir4("povf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    dir4("sub_bw", 32'h0000_0005, 32'h0000_0006, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    dir4("sub_ov", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // backpressure in DONE with a competing request
    send4(32'h0000_1234, 32'h0000_0010, 1'b0);
    wait_ov4(lat);
    held_sum = sum; held_c = cout; held_o = ovf;
    in_valid = 1'b1; a = 32'hAAAA_0000; b = 32'h0000_5555; sub = 1'b0;
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_sum_stable",  64'(sum),       64'(held_sum));
      check("bp_cout_stable", 64'(cout),      64'(held_c));
      check("bp_ovf_stable",  64'(ovf),       64'(held_o));
      check("bp_in_ready",    64'(in_ready),  64'd0);
      check("bp_out_valid",   64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    compare4();
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_in_ready_rise", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(model(32'hAAAA_0000, 32'h0000_5555, 1'b0, 32));
    check("bp_accept_busy", 64'(busy), 64'd1);
    recv4(1, lat);
    check("bp_new_sum", 64'(sum), 64'hAAAA_5555);

    // reset in the middle of RUN
    send4(32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy",      64'(busy),      64'd0);
    check("abort_in_ready",  64'(in_ready),  64'd1);
    check("abort_sum",       64'(sum),       64'd0);
    e = exp_q.pop_back();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    dir4("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    // random regression, WORDS=4
    for (int i = 0; i < 200; i++) begin
      send4($urandom, $urandom, 1'($urandom_range(0, 1)));
      recv4(3, lat);
    end

    // WORDS=1: a single RUN cycle
    txn1(8'h7F, 8'h01, 1'b0, 0, lat);
    check("latency1", 64'(lat), 64'd1);
    check("w1_ovf",   64'(ovf1), 64'd1);
    for (int i = 0; i < 200; i++) begin
      txn1(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 3, lat);
    end

    check("queue_drained", 64'(exp_q.size() + exp1_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
- Word-serial multi-precision add/subtract controller.
- Time-shares one instance of the existing N-bit ripple adder (n_bit_adder) across WORDS slices of a wide operand pair.
- Chains the slice-to-slice carry through a register and returns one wide result per transaction over valid/ready handshakes.
- Sits between a requester that needs wide arithmetic and the narrow shared adder datapath.

Parameters:
N, 8, width of one adder slice (n of the instantiated n_bit_adder); legal N >= 2
WORDS, 4, slices per operand; legal WORDS >= 1; total width W = N*WORDS

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request present
in_ready  output  1  block can accept a request
a  input  W  operand A, two's complement
b  input  W  operand B, two's complement
sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
sum  output  W  registered result
cout  output  1  final carry out; for sub, 1 = no borrow (A >= B unsigned)
ovf  output  1  signed two's-complement overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; sum=0, cout=0, ovf=0; out_valid=0; busy=0; in_ready=1; slice index=0; carry register=0.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE). busy = (state!=IDLE). out_valid = (state==DONE). All are decoded from registered state only; no combinational path from inputs.
- IDLE:
  - On in_valid && in_ready: capture a_reg=a and b_reg = sub ? ~b : b.
  - Set carry register = sub, index=0, go to RUN.
  - in_valid without acceptance has no effect.
- RUN, one slice per cycle:
  - The adder sees a_reg[idx*N +: N], b_reg[idx*N +: N], cin = carry register.
  - At the clock edge: sum[idx*N +: N] <= adder sum; carry register <= adder cout; idx <= idx+1.
  - On the edge that writes idx==WORDS-1:
    - cout <= adder cout.
    - ovf <= (a_reg[W-1]==b_reg[W-1]) && (slice sum MSB != a_reg[W-1]).
    - idx <= 0; go to DONE.
  - in_valid is ignored throughout RUN.
- DONE:
  - sum, cout and ovf are held stable.
  - On out_valid && out_ready, go to IDLE. in_ready rises the cycle after the output handshake; no overlap of transactions.
- Latency: accept at edge k; out_valid is high from edge k+WORDS onward. WORDS=1 gives one RUN cycle.
- sum updates slice by slice during RUN and is defined only while out_valid=1. After the output handshake it holds its value until the next RUN overwrites it.
- out_ready is ignored unless out_valid=1.
- Reset asserted in any state aborts the operation immediately: all reset values apply and no partial result is presented.
- Arithmetic wraps modulo 2^W. Carry between slices is strictly the registered carry; no combinational path crosses slices.

Test Plan:
- N=8, WORDS=4, add a=0x000000FF, b=0x00000001 -> sum=0x00000100, cout=0, ovf=0; out_valid exactly 4 cycles after the input handshake edge.
- Add a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, cout=1, ovf=0. Add a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, ovf=1.
- Sub a=5, b=6 -> sum=0xFFFFFFFF, cout=0, ovf=0. Sub a=0x80000000, b=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Backpressure: out_ready=0 for 3 cycles in DONE with in_valid=1 and a new operand pair -> sum/cout/ovf stable, in_ready=0, new request not taken. Raise out_ready -> in_ready=1 the next cycle, new request accepted, correct result.
- Reset mid-RUN: drop rst_n after 2 RUN cycles -> out_valid=0, busy=0, in_ready=1 immediately. Next request a=0x12345678, b=0x11111111 add -> sum=0x23456789, cout=0, ovf=0.
- Random regression: 200 random a, b, sub with random out_ready stalls -> sum/cout/ovf match a W+1-bit reference model every transaction. Repeat with WORDS=1.
